// File: rtl/processor_io_pkg.sv
// Shared types and helpers for the processor board-I/O input path.
// Pure declarations; no timing of its own.
// No handshake; consumers import what they need.
package processor_io_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int DATA_W     = 32;
    localparam int SW_W       = 16;
    localparam int ACC_W      = 14;   // holds 0..9999

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_HOLD
    } state_e;

    // True when every nibble of the switch word is a decimal digit.
    function automatic logic bcd_ok(input logic [SW_W-1:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (d[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Digit idx of the latched word, idx 3 being the most significant.
    function automatic logic [3:0] bcd_digit(input logic [SW_W-1:0] d, input logic [1:0] idx);
        return d[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/processor_input_port_if.sv
// Board-side and control-side signals of the processor input port.
// Wiring only; no latency.
// data_valid/data_take form the handshake; the port never blocks the board.
interface processor_input_port_if;
    import processor_io_pkg::*;

    logic [SW_W-1:0]   sw;
    logic              button;
    logic              bcd_mode;
    logic              data_take;
    logic              data_valid;
    logic [DATA_W-1:0] data_out;
    logic              overrun;
    logic              bcd_err;

    modport master (
        output sw, button, bcd_mode, data_take,
        input  data_valid, data_out, overrun, bcd_err
    );

    modport slave (
        input  sw, button, bcd_mode, data_take,
        output data_valid, data_out, overrun, bcd_err
    );

endinterface

// File: rtl/processor_debounce.sv
// Synchronises an active-low button, debounces it and pulses once per clean press.
// Press pulse 2 sync cycles + DEBOUNCE_CYCLES after the level settles, registered.
// No backpressure; the pulse is a single cycle and is lost if not used.
module processor_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic press
);

    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             flush1_q, flush1_d, flush2_q, flush2_d;
    logic             armed_q, armed_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count cycles of disagreement with the stable level; flip after a full window.
    // Events are only armed once the button has been seen released after reset
    // (flush flops mark when sync2 reflects the real pin), so a press held through
    // reset cannot produce an event.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        flush1_d = 1'b1;
        flush2_d = flush1_q;
        armed_d  = armed_q | (flush2_q & sync2_q);
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = stable_q & ~stable_d & armed_q;
    end

    // State registers; button path resets to the released level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            flush1_q <= 1'b0;
            flush2_q <= 1'b0;
            armed_q  <= 1'b0;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            flush1_q <= flush1_d;
            flush2_q <= flush2_d;
            armed_q  <= armed_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/processor_input_port.sv
// Captures switches on each clean button press, optional BCD->binary, valid/take hold.
// data_valid 1 cycle after the press event (binary) or 5 cycles (BCD).
// Presses arriving while a value is converting or pending are dropped and flag overrun.
module processor_input_port
    import processor_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    processor_input_port_if.slave   io
);

    logic              press;
    logic              take_ok;
    logic [ACC_W-1:0]  acc_next;

    logic [SW_W-1:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic              mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
    state_e            state_q, state_d;
    logic [SW_W-1:0]   digits_q, digits_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              bcd_err_q, bcd_err_d;

    processor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .din   (io.button),
        .press (press)
    );

    // Capture FSM, BCD multiply-accumulate (acc*8 + acc*2 + digit) and sticky flags.
    always_comb begin
        sw_s1_d    = io.sw;
        sw_s2_d    = sw_s1_q;
        mode_s1_d  = io.bcd_mode;
        mode_s2_d  = mode_s1_q;
        state_d    = state_q;
        digits_d   = digits_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        bcd_err_d  = bcd_err_q;
        overrun_d  = overrun_q;
        take_ok    = io.data_take & valid_q;
        acc_next   = (acc_q << 3) + (acc_q << 1) + ACC_W'(bcd_digit(digits_q, idx_q));

        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    if (!mode_s2_q) begin
                        data_out_d = {{(DATA_W-SW_W){sw_s2_q[SW_W-1]}}, sw_s2_q};
                        valid_d    = 1'b1;
                        bcd_err_d  = 1'b0;
                        state_d    = ST_HOLD;
                    end else begin
                        digits_d = sw_s2_q;
                        if (bcd_ok(sw_s2_q)) begin
                            bcd_err_d = 1'b0;
                            acc_d     = '0;
                            idx_d     = 2'd3;
                            state_d   = ST_CONVERT;
                        end else begin
                            bcd_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_CONVERT: begin
                acc_d = acc_next;
                idx_d = idx_q - 2'd1;
                if (idx_q == 2'd0) begin
                    data_out_d = DATA_W'(acc_next);
                    valid_d    = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (take_ok) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A dropped press outranks a same-cycle take when deciding overrun.
        if (press && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (take_ok) begin
            overrun_d = 1'b0;
        end
    end

    // State registers; reset discards any value in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            mode_s1_q  <= 1'b0;
            mode_s2_q  <= 1'b0;
            state_q    <= ST_IDLE;
            digits_q   <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            bcd_err_q  <= 1'b0;
        end else begin
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
            mode_s1_q  <= mode_s1_d;
            mode_s2_q  <= mode_s2_d;
            state_q    <= state_d;
            digits_q   <= digits_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            bcd_err_q  <= bcd_err_d;
        end
    end

    assign io.data_valid = valid_q;
    assign io.data_out   = data_out_q;
    assign io.overrun    = overrun_q;
    assign io.bcd_err    = bcd_err_q;

endmodule
